// File: rtl/mario_pkg.sv
// Shared types and default timing constants for Mario's power-state sequencer.
package mario_pkg;

  typedef enum logic [2:0] {
    StSmall,
    StGrow,
    StBig,
    StShrink,
    StDead
  } power_state_t;

  localparam int unsigned GROW_FRAMES_DEF   = 12;
  localparam int unsigned INVULN_FRAMES_DEF = 120;
  localparam int unsigned BLINK_SHIFT_DEF   = 2;

endpackage

// File: rtl/mario_power_ctrl_if.sv
// Per-frame collision events in, sprite/world control flags out.
interface mario_power_ctrl_if;
  logic frame_tick;
  logic mushroom_hit;
  logic enemy_hit;
  logic pit_fall;
  logic super_mario;
  logic freeze;
  logic invulnerable;
  logic visible;
  logic dead;

  modport master (
    output frame_tick, mushroom_hit, enemy_hit, pit_fall,
    input  super_mario, freeze, invulnerable, visible, dead
  );

  modport slave (
    input  frame_tick, mushroom_hit, enemy_hit, pit_fall,
    output super_mario, freeze, invulnerable, visible, dead
  );
endinterface

// File: rtl/mario_frame_timer.sv
// Loadable, tick-enabled down-counter that saturates at zero.
module mario_frame_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] cnt,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign zero = (cnt_q == '0);
  assign cnt  = cnt_q;

  // clear beats load beats decrement
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      if (clear) begin
        cnt_d = '0;
      end else if (load) begin
        cnt_d = load_val;
      end else if (!zero) begin
        cnt_d = cnt_q - Width'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mario_power_ctrl.sv
// Mario power-state FSM: grow/shrink animations and post-hit invulnerability, timed in frames.
module mario_power_ctrl
  import mario_pkg::*;
#(
  parameter int unsigned GROW_FRAMES   = GROW_FRAMES_DEF,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int unsigned BLINK_SHIFT   = BLINK_SHIFT_DEF
) (
  input logic             Clk,
  input logic             Reset_n,
  mario_power_ctrl_if.slave bus
);

  localparam int unsigned FcW = $clog2(GROW_FRAMES);
  localparam int unsigned IcW = $clog2(INVULN_FRAMES + 1);
  // Value held on the tick that advances frame_cnt to GROW_FRAMES-1, i.e. the exit tick.
  localparam logic [FcW-1:0] FcExit = FcW'(GROW_FRAMES - 2);

  power_state_t     state_q, state_d;
  logic [FcW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [FcW:0]     frame_cnt_ext;
  logic [IcW-1:0]   inv_cnt, inv_shr;
  logic             inv_zero, inv_load, inv_clear;
  logic             invulnerable;

  mario_frame_timer #(
    .Width (IcW)
  ) u_inv_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .tick     (bus.frame_tick),
    .clear    (inv_clear),
    .load     (inv_load),
    .load_val (IcW'(INVULN_FRAMES)),
    .cnt      (inv_cnt),
    .zero     (inv_zero)
  );

  assign invulnerable = !inv_zero || (state_q == StGrow) || (state_q == StShrink);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    inv_load    = 1'b0;
    inv_clear   = 1'b0;
    if (bus.frame_tick) begin
      unique case (state_q)
        StSmall: begin
          if (bus.pit_fall || (bus.enemy_hit && !invulnerable)) begin
            state_d   = StDead;
            inv_clear = 1'b1;
          end else if (bus.mushroom_hit) begin
            state_d     = StGrow;
            frame_cnt_d = '0;
          end
        end
        StGrow: begin
          frame_cnt_d = frame_cnt_q + FcW'(1);
          if (frame_cnt_q == FcExit) state_d = StBig;
        end
        StBig: begin
          if (bus.pit_fall) begin
            state_d   = StDead;
            inv_clear = 1'b1;
          end else if (bus.enemy_hit) begin
            state_d     = StShrink;
            frame_cnt_d = '0;
          end
        end
        StShrink: begin
          frame_cnt_d = frame_cnt_q + FcW'(1);
          if (frame_cnt_q == FcExit) begin
            state_d  = StSmall;
            inv_load = 1'b1;
          end
        end
        StDead: state_d = StDead;
        default: state_d = StSmall;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= StSmall;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Zero-extended copies keep the bit selects legal for the narrowest parameter choices.
  assign frame_cnt_ext = {1'b0, frame_cnt_q};
  assign inv_shr       = inv_cnt >> BLINK_SHIFT;

  always_comb begin
    bus.super_mario = 1'b0;
    bus.freeze      = 1'b0;
    unique case (state_q)
      StGrow, StShrink: begin
        bus.super_mario = frame_cnt_ext[1];
        bus.freeze      = 1'b1;
      end
      StBig:   bus.super_mario = 1'b1;
      StDead:  bus.freeze      = 1'b1;
      default: ;
    endcase
  end

  assign bus.invulnerable = invulnerable;
  assign bus.visible      = !(!inv_zero && inv_shr[0]);
  assign bus.dead         = (state_q == StDead);

endmodule

// File: tb/tb_mario_power_ctrl.sv
// Directed bench for mario_power_ctrl with GROW_FRAMES=4, INVULN_FRAMES=8, BLINK_SHIFT=1.
module tb_mario_power_ctrl;

  logic Clk = 1'b0;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  mario_power_ctrl_if bus ();

  mario_power_ctrl #(
    .GROW_FRAMES   (4),
    .INVULN_FRAMES (8),
    .BLINK_SHIFT   (1)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // order: super_mario, freeze, invulnerable, visible, dead
  task automatic check_outs(input string tag, input logic sm, input logic fr, input logic iv,
                            input logic vi, input logic dd);
    check({tag, ".super"}, 32'(bus.super_mario), 32'(sm));
    check({tag, ".freeze"}, 32'(bus.freeze), 32'(fr));
    check({tag, ".invuln"}, 32'(bus.invulnerable), 32'(iv));
    check({tag, ".visible"}, 32'(bus.visible), 32'(vi));
    check({tag, ".dead"}, 32'(bus.dead), 32'(dd));
  endtask

  // One frame strobe carrying the given event levels, then one idle cycle; returns at a negedge.
  task automatic tick(input logic mh, input logic eh, input logic pf);
    @(negedge Clk);
    bus.frame_tick   = 1'b1;
    bus.mushroom_hit = mh;
    bus.enemy_hit    = eh;
    bus.pit_fall     = pf;
    @(negedge Clk);
    bus.frame_tick   = 1'b0;
    bus.mushroom_hit = 1'b0;
    bus.enemy_hit    = 1'b0;
    bus.pit_fall     = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Small -> Big through a full grow animation, checking each step.
  task automatic grow_to_big(input string tag);
    logic exp_sm[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_fr[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1 && (i == 0), 1'b0, 1'b0);
      check($sformatf("%s.t%0d.super", tag, i + 1), 32'(bus.super_mario), 32'(exp_sm[i]));
      check($sformatf("%s.t%0d.freeze", tag, i + 1), 32'(bus.freeze), 32'(exp_fr[i]));
    end
  endtask

  logic exp_vis[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic exp_inv[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    Reset_n          = 1'b0;
    bus.frame_tick   = 1'b0;
    bus.mushroom_hit = 1'b0;
    bus.enemy_hit    = 1'b0;
    bus.pit_fall     = 1'b0;

    // Reset and idle
    do_reset();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (50) tick(1'b0, 1'b0, 1'b0);
    check_outs("idle50", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Grow, then a mushroom in Big does nothing
    grow_to_big("grow");
    check_outs("big", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_outs("big_mush", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Hit while big: four shrink ticks, last one lands in Small with inv_cnt=8
    tick(1'b0, 1'b1, 1'b0);
    check_outs("shr1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_outs("shr2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_outs("shr3", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_outs("shr_exit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // Window counts 7..0; an enemy hit on the third tick must be masked
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, (i == 2), 1'b0);
      check($sformatf("win%0d.invuln", i), 32'(bus.invulnerable), 32'(exp_inv[i]));
      check($sformatf("win%0d.visible", i), 32'(bus.visible), 32'(exp_vis[i]));
      check($sformatf("win%0d.dead", i), 32'(bus.dead), 32'(1'b0));
    end
    tick(1'b0, 1'b1, 1'b0);
    check_outs("hit_small", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_outs("dead_hold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Priority: pit beats enemy in Big, death is absorbing
    do_reset();
    check_outs("reset2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    grow_to_big("grow2");
    tick(1'b0, 1'b1, 1'b1);
    check_outs("prio", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_outs("prio_mush", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Off-tick mushroom pulse is ignored
    do_reset();
    @(negedge Clk);
    bus.mushroom_hit = 1'b1;
    @(negedge Clk);
    bus.mushroom_hit = 1'b0;
    repeat (2) @(negedge Clk);
    check_outs("offtick", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_outs("offtick_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-animation reset on the second grow tick, then a full regrow
    tick(1'b1, 1'b0, 1'b0);
    check_outs("mid_g1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    bus.frame_tick = 1'b1;
    Reset_n        = 1'b0;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    Reset_n = 1'b1;
    @(negedge Clk);
    grow_to_big("regrow");
    check_outs("regrow_big", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
